// File: rtl/button_pio_debounced.sv
// ---------------------------------------------------------------------------
// button_pio_debounced
//
// Memory-mapped input port for push-buttons and switches on an Avalon-MM bus.
// Each input channel has a 2-flop synchroniser, a debounce filter, an edge
// capture register and an interrupt mask. The masked, captured edges are
// combined into one level-sensitive irq.
//
// Register map (word addresses; unused upper bits read 0, writes ignored):
//   0 DATA    (RO)   stable (debounced) levels
//   1 RAW     (RO)   synchroniser output, not debounced
//   2 IRQMASK (RW)   bit n enables the interrupt for channel n
//   3 EDGECAP (W1C)  captured edges; writing 1 clears that bit
//
// Optional feature macro: BUTTON_PIO_DEBOUNCE_EN
//   defined   - per-channel debounce counters filter sync1 into stable
//   undefined - no counters; stable follows sync1 one cycle later
//
// Ports:
//   clk         system clock (the only clock)
//   reset       synchronous, active-high reset
//   address     register select
//   chipselect  slave select
//   write       write strobe, qualified by chipselect
//   writedata   write data
//   readdata    registered read data (fixed read latency 1)
//   in_port     asynchronous button/switch inputs
//   irq         interrupt request, active high
// ---------------------------------------------------------------------------
module button_pio_debounced #(
    parameter int unsigned      WIDTH           = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter int unsigned      CNT_W           = 16,
    parameter int unsigned      EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // Elaboration-time parameter range checks.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("button_pio_debounced: WIDTH must be 1..32");
    end
    if (EDGE_TYPE > 2) begin : g_bad_edge_type
        $error("button_pio_debounced: EDGE_TYPE must be 0, 1 or 2");
    end
    if (DEBOUNCE_CYCLES < 2 || 64'(DEBOUNCE_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_debounce
        $error("button_pio_debounced: DEBOUNCE_CYCLES must be 2..2^CNT_W-1");
    end

    logic [WIDTH-1:0] sync0;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] irqmask;

    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr;
    logic             wr_irqmask;
    logic [31:0]      rd_next;

    // Upper writedata bits beyond WIDTH are deliberately ignored.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        edge_hit   = '0;
        clr        = '0;
        wr_irqmask = 1'b0;
        rd_next    = '0;

        if (EDGE_TYPE == 0) begin
            edge_hit = stable & ~stable_d;
        end else if (EDGE_TYPE == 1) begin
            edge_hit = ~stable & stable_d;
        end else begin
            edge_hit = stable ^ stable_d;
        end

        if (chipselect && write) begin
            if (address == 2'd3) clr = writedata[WIDTH-1:0];
            wr_irqmask = (address == 2'd2);
        end

        case (address)
            2'd0:    rd_next[WIDTH-1:0] = stable;
            2'd1:    rd_next[WIDTH-1:0] = sync1;
            2'd2:    rd_next[WIDTH-1:0] = irqmask;
            default: rd_next[WIDTH-1:0] = edgecap;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync0    <= RESET_VALUE;
            sync1    <= RESET_VALUE;
            // stable_d matches stable so reset release never looks like an edge.
            stable_d <= RESET_VALUE;
            edgecap  <= '0;
            irqmask  <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            sync0    <= in_port;
            sync1    <= sync0;
            stable_d <= stable;
            // Set wins over clear: an edge arriving with its own clear stays captured.
            edgecap  <= (edgecap & ~clr) | edge_hit;
            if (wr_irqmask) irqmask <= writedata[WIDTH-1:0];
            irq      <= |(edgecap & irqmask);
            readdata <= rd_next;
        end
    end

`ifdef BUTTON_PIO_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt [WIDTH];

    // A channel's counter runs only while sync1 disagrees with stable; any
    // agreement restarts it, so a glitch shorter than DEBOUNCE_CYCLES is lost.
    // The counter stops at CNT_LAST and never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= RESET_VALUE;
            // NOTE: the counter array is plain flops, not RAM, so resetting it
            // costs nothing and guarantees a mid-debounce reset discards progress.
            for (int n = 0; n < int'(WIDTH); n++) cnt[n] <= '0;
        end else begin
            for (int n = 0; n < int'(WIDTH); n++) begin
                if (sync1[n] == stable[n]) begin
                    cnt[n] <= '0;
                end else if (cnt[n] == CNT_LAST) begin
                    stable[n] <= sync1[n];
                    cnt[n]    <= '0;
                end else begin
                    cnt[n] <= cnt[n] + CNT_W'(1);
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= RESET_VALUE;
        end else begin
            stable <= sync1;
        end
    end
`endif

endmodule

// File: tb/tb_button_pio_debounced.sv
// ---------------------------------------------------------------------------
// tb_button_pio_debounced
//
// Directed testbench for button_pio_debounced with WIDTH=2, DEBOUNCE_CYCLES=4,
// EDGE_TYPE=1 (falling). Inputs are driven and outputs sampled on the falling
// clock edge. A register read issued at negedge N returns the state held
// between posedges at N (readdata is registered, latency 1).
// Input-to-DATA latency LAT is 2+DEBOUNCE_CYCLES with BUTTON_PIO_DEBOUNCE_EN
// defined and 3 without it.
// ---------------------------------------------------------------------------
module tb_button_pio_debounced;

    localparam int DB = 4;
`ifdef BUTTON_PIO_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  in_port;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_pio_debounced #(
        .WIDTH           (2),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (4),
        .EDGE_TYPE       (1),
        .RESET_VALUE     (2'b11)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write      = 1'b1;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        in_port = 2'b11; reset = 1'b1; address = 2'd0;
        chipselect = 1'b0; write = 1'b0; writedata = '0;
        step(3);
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        reset = 1'b0;
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL reset_data: got %h expected %h", rd, 32'h3); end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_edgecap: got %h expected %h", rd, 32'h0); end
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_irqmask: got %h expected %h", rd, 32'h0); end
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL reset_raw: got %h expected %h", rd, 32'h3); end
        bus_write(2'd0, 32'h0);
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL data_write_ignored: got %h expected %h", rd, 32'h3); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq_idle: got %b expected 0", irq); end
    endtask

    // 3-cycle low pulse on bit 0: visible on RAW, filtered out of DATA.
    task automatic test_glitch;
        logic [31:0] rd;
        in_port = 2'b10;              // N0
        step(2);                      // N2: sync1 holds the glitch
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL glitch_raw: got %h expected %h", rd, 32'h2); end
        in_port = 2'b11;              // N3: glitch lasted 3 cycles
        bus_read(2'd0, rd);
`ifdef BUTTON_PIO_DEBOUNCE_EN
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL glitch_data_mid: got %h expected %h", rd, 32'h3); end
`else
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL glitch_data_mid: got %h expected %h", rd, 32'h2); end
`endif
        step(8);
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL glitch_data_end: got %h expected %h", rd, 32'h3); end
        bus_read(2'd3, rd);
`ifdef BUTTON_PIO_DEBOUNCE_EN
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL glitch_edgecap: got %h expected %h", rd, 32'h0); end
`else
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL glitch_edgecap: got %h expected %h", rd, 32'h1); end
`endif
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL glitch_edgecap_clr: got %h expected %h", rd, 32'h0); end
    endtask

    // Held drop on bit 0: DATA changes at N(LAT), EDGECAP at N(LAT+1), irq at N(LAT+2).
    task automatic test_debounce_irq;
        logic [31:0] rd;
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL irqmask_write: got %h expected %h", rd, 32'h1); end
        in_port = 2'b10;              // N0
        step(LAT - 1);
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL data_before_lat: got %h expected %h", rd, 32'h3); end
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL data_at_lat: got %h expected %h", rd, 32'h2); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", irq); end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL edgecap_set: got %h expected %h", rd, 32'h1); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", irq); end
    endtask

    task automatic test_clear;
        logic [31:0] rd;
        bus_write(2'd3, 32'h1);       // N1
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_clr_n1: got %b expected 1", irq); end
        step(1);                      // N2
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr_n2: got %b expected 0", irq); end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL edgecap_clr: got %h expected %h", rd, 32'h0); end
        // Rising edge must not be captured.
        in_port = 2'b11;
        step(LAT + 3);
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL rise_ignored: got %h expected %h", rd, 32'h0); end
        // First fall sets EDGECAP, rise restores, second fall lands on the clear.
        in_port = 2'b10;
        step(LAT + 2);
        in_port = 2'b11;
        step(LAT + 2);
        in_port = 2'b10;              // N0
        step(LAT);                    // N(LAT)
        bus_write(2'd3, 32'h1);       // clear active at P(LAT+1) with the new edge
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL set_wins: got %h expected %h", rd, 32'h1); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq: got %b expected 1", irq); end
    endtask

    task automatic test_mask;
        logic [31:0] rd;
        bus_write(2'd3, 32'h3);
        bus_write(2'd2, 32'h0);
        step(1);
        in_port = 2'b00;              // N0: bit 1 falls
        step(LAT + 2);
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL mask_edgecap: got %h expected %h", rd, 32'h2); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq: got %b expected 0", irq); end
        bus_write(2'd2, 32'h2);       // N1
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL unmask_irq_n1: got %b expected 0", irq); end
        step(1);                      // N2
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL unmask_irq_n2: got %b expected 1", irq); end
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL irqmask_readback: got %h expected %h", rd, 32'h2); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        in_port = 2'b11;
        step(LAT + 3);
        in_port = 2'b10;              // N0
        step(4);                      // N4: counter at 2 when debounced
        reset = 1'b1;
        step(2);
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL mid_reset_readdata: got %h expected %h", readdata, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq: got %b expected 0", irq); end
        reset = 1'b0;                 // R0, in_port stays low on bit 0
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL mid_reset_data: got %h expected %h", rd, 32'h3); end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL mid_reset_edgecap: got %h expected %h", rd, 32'h0); end
        bus_read(2'd2, rd);           // now R3
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL mid_reset_irqmask: got %h expected %h", rd, 32'h0); end
`ifdef BUTTON_PIO_DEBOUNCE_EN
        step(2);                      // R5
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL mid_reset_restart: got %h expected %h", rd, 32'h3); end
        bus_read(2'd0, rd);           // state R6
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL mid_reset_redebounce: got %h expected %h", rd, 32'h2); end
`else
        bus_read(2'd0, rd);           // state R3
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL nodeb_data_lat3: got %h expected %h", rd, 32'h2); end
`endif
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL mid_reset_new_edge: got %h expected %h", rd, 32'h1); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq_masked: got %b expected 0", irq); end
    endtask

    initial begin
        test_reset;
        test_glitch;
        test_debounce_irq;
        test_clear;
        test_mask;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
